// File: rtl/muxn_rr_arbiter.sv
// Round-robin arbiter that shares one muxn datapath among 2^NB_SEL requesters.
// The owner keeps the grant while it requests. After MAX_HOLD cycles it gives
// way through a one-cycle gap if another requester is waiting.
module muxn_rr_arbiter #(
    parameter int NB_SEL   = 2,
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4,
    localparam int N       = 1 << NB_SEL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req,
    output logic [N-1:0]      gnt,
    output logic              gnt_valid,
    output logic [NB_SEL-1:0] sel,
    output logic [CNT_W-1:0]  hold_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        OWNED,
        HANDOVER
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

    state_t              state_q, state_d;
    logic [N-1:0]        gnt_q, gnt_d;
    logic [NB_SEL-1:0]   sel_q, sel_d;
    logic [NB_SEL-1:0]   last_q, last_d;
    logic [CNT_W-1:0]    hold_q, hold_d;

    logic [N-1:0]        others;
    logic [NB_SEL:0]     pick_all, pick_oth;
    logic                do_grant;
    logic [NB_SEL-1:0]   win;

    // First requester after 'base' in circular order; MSB flags a hit.
    function automatic logic [NB_SEL:0] rr_pick(input logic [N-1:0] r,
                                                input logic [NB_SEL-1:0] base);
        logic [NB_SEL:0]   res;
        logic [NB_SEL-1:0] idx;
        res = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = NB_SEL'(32'(base) + k);
            if (!res[NB_SEL] && r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign others   = req & ~(N'(1) << sel_q);
    assign pick_all = rr_pick(req, last_q);
    assign pick_oth = rr_pick(others, last_q);

    // Next-state, grant selection and hold counter update
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        sel_d    = sel_q;
        last_d   = last_q;
        hold_d   = hold_q;
        do_grant = 1'b0;
        win      = sel_q;

        unique case (state_q)
            IDLE: begin
                if (pick_all[NB_SEL]) begin
                    do_grant = 1'b1;
                    win      = pick_all[NB_SEL-1:0];
                end
            end
            OWNED: begin
                if (!req[sel_q]) begin
                    if (pick_oth[NB_SEL]) begin
                        do_grant = 1'b1;
                        win      = pick_oth[NB_SEL-1:0];
                    end else begin
                        gnt_d   = '0;
                        hold_d  = '0;
                        state_d = IDLE;
                    end
                end else if (MAX_HOLD != 0 && hold_q == HOLD_LAST && |others) begin
                    gnt_d   = '0;
                    hold_d  = '0;
                    state_d = HANDOVER;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            HANDOVER: begin
                if (pick_oth[NB_SEL]) begin
                    do_grant = 1'b1;
                    win      = pick_oth[NB_SEL-1:0];
                end else if (req[sel_q]) begin
                    do_grant = 1'b1;
                    win      = sel_q;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        if (do_grant) begin
            gnt_d   = N'(1) << win;
            sel_d   = win;
            last_d  = win;
            hold_d  = '0;
            state_d = OWNED;
        end
    end

    // State registers; last resets to N-1 so requester 0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            last_q  <= '1;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign sel       = sel_q;
    assign hold_cnt  = hold_q;

endmodule
